// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: one valid/ready pair carries operations in,
// a second valid/ready pair carries the registered result and status out.
interface alu_seq_if #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NumOpCodeBits-1:0] opcode;
  logic [DataWidth-1:0]     operand1;
  logic [DataWidth-1:0]     operand2;
  logic [ParamBits-1:0]     param;
  logic                     out_valid;
  logic                     out_ready;
  logic [DataWidth-1:0]     result;
  logic [NumStatusBits-1:0] status;

  // Producer/consumer side of the ALU.
  modport master (
    output in_valid, opcode, operand1, operand2, param, out_ready,
    input  in_ready, out_valid, result, status
  );

  // The ALU itself.
  modport slave (
    input  in_valid, opcode, operand1, operand2, param, out_ready,
    output in_ready, out_valid, result, status
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, bit-serial shifts and a shift-add multiply,
// with the result and status registered behind an IDLE/EXEC/DONE state machine.
module alu_seq #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(DataWidth + 1);

  localparam logic [NumOpCodeBits-1:0] OP_ADD = NumOpCodeBits'(1);
  localparam logic [NumOpCodeBits-1:0] OP_SUB = NumOpCodeBits'(2);
  localparam logic [NumOpCodeBits-1:0] OP_AND = NumOpCodeBits'(3);
  localparam logic [NumOpCodeBits-1:0] OP_OR  = NumOpCodeBits'(4);
  localparam logic [NumOpCodeBits-1:0] OP_NOT = NumOpCodeBits'(5);
  localparam logic [NumOpCodeBits-1:0] OP_XOR = NumOpCodeBits'(6);
  localparam logic [NumOpCodeBits-1:0] OP_SHL = NumOpCodeBits'(7);
  localparam logic [NumOpCodeBits-1:0] OP_SHR = NumOpCodeBits'(8);
  localparam logic [NumOpCodeBits-1:0] OP_MUL = NumOpCodeBits'(10);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {K_SHL = 2'd0, K_SHR = 2'd1, K_MUL = 2'd2} kind_t;

  state_t                   state;
  kind_t                    kind;
  logic                     alive;
  logic [DataWidth-1:0]     lo;
  logic [DataWidth-1:0]     hi;
  logic [DataWidth-1:0]     mcand;
  logic [CW-1:0]            steps;
  logic [DataWidth-1:0]     result_q;
  logic [NumStatusBits-1:0] status_q;
  logic                     out_valid_q;

  logic                     in_ready_c;
  logic                     accept;
  logic [CW-1:0]            shift_cnt;
  logic [DataWidth-1:0]     sc_result;
  logic                     sc_carry;
  logic                     sc_under;
  logic                     sc_valid;
  logic [NumStatusBits-1:0] sc_status;
  logic                     go_exec;
  kind_t                    go_kind;
  logic [CW-1:0]            go_steps;
  logic [DataWidth:0]       step_sum;
  logic [DataWidth-1:0]     nxt_lo;
  logic [DataWidth-1:0]     nxt_hi;
  logic                     nxt_carry;
  logic [NumStatusBits-1:0] ex_status;

  // Handshake: a transfer happens on any cycle with in_valid & in_ready (operands captured then),
  // and a result is consumed on any cycle with out_valid & out_ready. in_ready follows out_ready
  // in DONE so a result can be consumed and the next operation accepted in the same cycle.
  assign in_ready_c    = alive && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.status    = status_q;
  assign dbg_state     = state;

  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_under  = 1'b0;
    sc_valid  = 1'b1;
    go_exec   = 1'b0;
    go_kind   = K_MUL;
    go_steps  = CW'(DataWidth);
    if (int'(bus.param) >= DataWidth) shift_cnt = CW'(DataWidth);
    else                              shift_cnt = CW'(bus.param);
    case (bus.opcode)
      OP_ADD: {sc_carry, sc_result} = {1'b0, bus.operand1} + {1'b0, bus.operand2};
      OP_SUB: begin
        sc_result = bus.operand1 - bus.operand2;
        sc_under  = bus.operand2 > bus.operand1;
      end
      OP_AND: sc_result = bus.operand1 & bus.operand2;
      OP_OR:  sc_result = bus.operand1 | bus.operand2;
      OP_NOT: sc_result = ~bus.operand2;
      OP_XOR: sc_result = bus.operand1 ^ bus.operand2;
      OP_SHL, OP_SHR: begin
        // A zero count completes immediately with the operand unchanged.
        if (shift_cnt == '0) begin
          sc_result = bus.operand1;
        end else begin
          go_exec  = 1'b1;
          go_kind  = (bus.opcode == OP_SHL) ? K_SHL : K_SHR;
          go_steps = shift_cnt;
        end
      end
      OP_MUL: go_exec = 1'b1;
      default: sc_valid = 1'b0;
    endcase
    sc_status = NumStatusBits'({sc_valid && (sc_result == '0), sc_under, sc_carry});
  end

  // One iteration: a 1-bit shift, or one shift-add multiply step on {hi, lo} with lo holding
  // the remaining multiplier bits.
  always_comb begin
    step_sum  = {1'b0, hi} + {1'b0, mcand & {DataWidth{lo[0]}}};
    nxt_lo    = lo;
    nxt_hi    = hi;
    nxt_carry = 1'b0;
    case (kind)
      K_SHL: begin
        nxt_lo    = lo << 1;
        nxt_carry = lo[DataWidth-1];
      end
      K_SHR: begin
        nxt_lo    = lo >> 1;
        nxt_carry = lo[0];
      end
      default: begin
        nxt_lo    = {step_sum[0], lo[DataWidth-1:1]};
        nxt_hi    = step_sum[DataWidth:1];
        nxt_carry = |step_sum[DataWidth:1];
      end
    endcase
    ex_status = NumStatusBits'({nxt_lo == '0, 1'b0, nxt_carry});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      kind        <= K_MUL;
      alive       <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      mcand       <= '0;
      steps       <= '0;
      result_q    <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (go_exec) begin
              lo          <= bus.operand1;
              hi          <= '0;
              mcand       <= bus.operand2;
              kind        <= go_kind;
              steps       <= go_steps;
              out_valid_q <= 1'b0;
              state       <= EXEC;
            end else begin
              result_q    <= sc_result;
              status_q    <= sc_status;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        EXEC: begin
          lo    <= nxt_lo;
          hi    <= nxt_hi;
          steps <= steps - 1'b1;
          if (steps == CW'(1)) begin
            result_q    <= nxt_lo;
            status_q    <= ex_status;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, backpressure, streaming, reset during a
// multiply, and randomized operations checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic       clock;
  logic       reset_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  logic [10:0] exp_q[$];

  alu_seq_if bus ();

  alu_seq dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model built from the opcode rules with plain integer arithmetic.
  function automatic void model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] p, output logic [7:0] r, output logic [2:0] s,
                                output int lat);
    int          cnt;
    int unsigned wide;
    logic        c;
    logic        u;
    bit          known;
    c = 1'b0; u = 1'b0; r = '0; lat = 1; known = 1'b1;
    cnt = (int'(p) > W) ? W : int'(p);
    case (op)
      5'd1: begin wide = a + b; r = wide[7:0]; c = wide[8]; end
      5'd2: begin r = a - b; u = (b > a); end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = ~b;
      5'd6: r = a ^ b;
      5'd7: begin
        r = a << cnt;
        if (cnt > 0) c = a[W-cnt];
        lat = 1 + cnt;
      end
      5'd8: begin
        r = a >> cnt;
        if (cnt > 0) c = a[cnt-1];
        lat = 1 + cnt;
      end
      5'd10: begin
        wide = a * b;
        r = wide[7:0];
        c = (wide >> W) != 0;
        lat = 1 + W;
      end
      default: known = 1'b0;
    endcase
    s = {known && (r == 8'd0), u, c};
  endfunction

  // Driver: present one operation, wait for acceptance, then count edges until out_valid.
  task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] p, output int lat, output logic [7:0] r,
                        output logic [2:0] s, output bit ok);
    int guard;
    ok = 1'b1;
    bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.param = p;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clock); #1; guard++;
    end
    if (guard >= 100) ok = 1'b0;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.opcode = 5'($urandom); bus.operand1 = 8'($urandom);
    bus.operand2 = 8'($urandom); bus.param = 8'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    if (lat >= 100) ok = 1'b0;
    r = bus.result;
    s = bus.status;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0; bus.param = '0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d want 0", bus.result); end
    checks++; if (bus.status !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", bus.status); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [4:0] t_op [12] = '{5'd1, 5'd2, 5'd2, 5'd7, 5'd7, 5'd10, 5'd10, 5'd8, 5'd0, 5'd9, 5'd5, 5'd8};
    logic [7:0] t_a  [12] = '{8'd200, 8'd5, 8'd9, 8'h81, 8'h80, 8'd16, 8'd12, 8'h81, 8'd5, 8'd3, 8'd0, 8'h01};
    logic [7:0] t_b  [12] = '{8'd100, 8'd7, 8'd9, 8'd0, 8'd0, 8'd16, 8'd10, 8'd0, 8'd5, 8'd3, 8'hFF, 8'd0};
    logic [7:0] t_p  [12] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] t_r  [12] = '{8'd44, 8'd254, 8'd0, 8'h02, 8'd0, 8'd0, 8'd120, 8'h81, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [2:0] t_s  [12] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b101, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b100, 3'b101};
    int         t_l  [12] = '{1, 1, 1, 2, 9, 9, 9, 1, 1, 1, 1, 2};
    int         lat;
    logic [7:0] r;
    logic [2:0] s;
    bit         ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_p[i], lat, r, s, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_timeout handshake did not complete", i); end
      checks++; if (r !== t_r[i]) begin errors++; $display("FAIL dir%0d_result got %0d want %0d", i, r, t_r[i]); end
      checks++; if (s !== t_s[i]) begin errors++; $display("FAIL dir%0d_status got %b want %b", i, s, t_s[i]); end
      checks++; if (lat != t_l[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t_l[i]); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    int         lat;
    logic [7:0] r;
    logic [2:0] s;
    bit         ok;
    bus.out_ready = 1'b0;
    run_op(5'd1, 8'd200, 8'd100, 8'd0, lat, r, s, ok);
    checks++; if (!ok || r !== 8'd44 || s !== 3'b001) begin
      errors++; $display("FAIL bp_first ok=%0d got %0d/%b want 44/001", ok, r, s);
    end
    bus.in_valid = 1'b1; bus.opcode = 5'd6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd44 || bus.status !== 3'b001) begin
        errors++; $display("FAIL bp_hold%0d got v=%b %0d/%b want v=1 44/001", i, bus.out_valid, bus.result, bus.status);
      end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, r;
    logic [2:0] s;
    logic [10:0] e;
    int         lat;
    bus.out_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a = 8'($urandom); b = 8'($urandom);
        bus.opcode = 5'd6; bus.operand1 = a; bus.operand2 = b; bus.param = '0;
        bus.in_valid = 1'b1;
        model(5'd6, a, b, 8'd0, r, s, lat);
        exp_q.push_back({s, r});
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got %b want 1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL stream_gap%0d got v=%b want 1", i, bus.out_valid);
        end else begin
          e = exp_q.pop_front();
          if ({bus.status, bus.result} !== e) begin
            errors++; $display("FAIL stream_data%0d got %h want %h", i, {bus.status, bus.result}, e);
          end
        end
      end
      if (i == 5) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_tail got v=%b want 0", bus.out_valid); end
      end
      @(negedge clock);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_mul;
    int         lat, seen, guard;
    logic [7:0] r;
    logic [2:0] s;
    bit         ok;
    bus.out_ready = 1'b1;
    run_op(5'd4, 8'h50, 8'h05, 8'd0, lat, r, s, ok);
    @(posedge clock); #1;
    bus.opcode = 5'd10; bus.operand1 = 8'd12; bus.operand2 = 8'd10; bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin @(posedge clock); #1; guard++; end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.result !== 8'd0 || bus.status !== 3'b000) begin
      errors++; $display("FAIL midmul_clear got v=%b %0d/%b want v=0 0/000", bus.out_valid, bus.result, bus.status);
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midmul_in_ready got %b want 0", bus.in_ready); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midmul_ghost got %0d valid cycles want 0", seen); end
    run_op(5'd1, 8'd3, 8'd4, 8'd0, lat, r, s, ok);
    checks++; if (!ok || r !== 8'd7 || s !== 3'b000 || lat != 1) begin
      errors++; $display("FAIL midmul_next ok=%0d got %0d/%b lat %0d want 7/000 lat 1", ok, r, s, lat);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    logic [4:0] op_list [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10};
    logic [4:0] op;
    logic [7:0] a, b, p, r, r_exp;
    logic [2:0] s, s_exp;
    int         lat, lat_exp, hold;
    bit         ok;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else                           op = op_list[$urandom_range(0, 9)];
      a = 8'($urandom); b = 8'($urandom);
      p = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      hold = $urandom_range(0, 2);
      model(op, a, b, p, r_exp, s_exp, lat_exp);
      bus.out_ready = (hold == 0);
      run_op(op, a, b, p, lat, r, s, ok);
      checks++; if (!ok || r !== r_exp || s !== s_exp || lat != lat_exp) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h p=%0d ok=%0d got %h/%b lat %0d want %h/%b lat %0d",
                 i, op, a, b, p, ok, r, s, lat, r_exp, s_exp, lat_exp);
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clock); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== r_exp || bus.status !== s_exp) begin
          errors++; $display("FAIL rand%0d_hold got v=%b %h/%b want v=1 %h/%b", i, bus.out_valid, bus.result, bus.status, r_exp, s_exp);
        end
      end
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
